// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: quantity/stock check, coin payment with timeout,
// per-item dispenser handshake, change computation and sale reporting.
module vend_txn_ctrl #(
    parameter int unsigned QTY_MAX     = 4,
    parameter int unsigned PRICE_W     = 8,
    parameter int unsigned MONEY_W     = 11,
    parameter int unsigned PAY_TIMEOUT = 500000000,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         slot,
    input  logic [2:0]         qty,
    input  logic [PRICE_W-1:0] price,
    input  logic [3:0]         stock,
    input  logic               coin_valid,
    input  logic [1:0]         coin_val,
    input  logic               cancel,
    output logic               disp_req,
    output logic [2:0]         disp_slot,
    input  logic               disp_ack,
    output logic [MONEY_W-1:0] paid,
    output logic [MONEY_W-1:0] total,
    output logic [MONEY_W-1:0] change,
    output logic               busy,
    output logic               finish,
    output logic               success,
    output logic               out,
    output logic               sale_inc_valid,
    output logic [MONEY_W-1:0] sale_inc
);

    localparam int unsigned PAY_CNT_W = (PAY_TIMEOUT > 1) ? $clog2(PAY_TIMEOUT) : 1;
    localparam int unsigned ACK_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PAY, S_DISPENSE, S_WAIT_ACK, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [2:0]           qty_q, qty_d;
    logic [PRICE_W-1:0]   price_q, price_d;
    logic [2:0]           dlv_q, dlv_d;
    logic [PAY_CNT_W-1:0] pay_cnt_q, pay_cnt_d;
    logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic                 ok_q, ok_d;
    logic                 soldout_q, soldout_d;
    logic [MONEY_W-1:0]   paid_d, total_d, change_d, sale_inc_d;
    logic                 busy_d, disp_req_d, finish_d, success_d, out_d, sale_inc_valid_d;
    logic [2:0]           disp_slot_d;
    logic [MONEY_W-1:0]   coin_amt, paid_new, sold_amt;
    logic [MONEY_W:0]     paid_sum;

    // Coin decode and saturating accumulation
    always_comb begin
        coin_amt = '0;
        case (coin_val)
            2'b00:   coin_amt = MONEY_W'(1);
            2'b01:   coin_amt = MONEY_W'(5);
            2'b10:   coin_amt = MONEY_W'(10);
            default: coin_amt = MONEY_W'(20);
        endcase
        paid_sum = {1'b0, paid} + {1'b0, coin_amt};
        paid_new = paid;
        if (coin_valid) begin
            paid_new = paid_sum[MONEY_W] ? '1 : paid_sum[MONEY_W-1:0];
        end
        sold_amt = MONEY_W'(price_q) * MONEY_W'(dlv_q);
    end

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        qty_d     = qty_q;
        price_d   = price_q;
        dlv_d     = dlv_q;
        pay_cnt_d = pay_cnt_q;
        ack_cnt_d = ack_cnt_q;
        ok_d      = ok_q;
        soldout_d = soldout_q;
        paid_d    = paid;
        total_d   = total;
        change_d  = change;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    slot_d    = slot;
                    qty_d     = qty;
                    price_d   = price;
                    paid_d    = '0;
                    change_d  = '0;
                    dlv_d     = '0;
                    ok_d      = 1'b0;
                    soldout_d = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                total_d = MONEY_W'(price_q) * MONEY_W'(qty_q);
                if (qty_q == 3'd0 || 32'(qty_q) > QTY_MAX) begin
                    state_d = S_DONE;
                end else if (stock < 4'(qty_q)) begin
                    soldout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    pay_cnt_d = '0;
                    state_d   = S_PAY;
                end
            end
            S_PAY: begin
                paid_d    = paid_new;
                pay_cnt_d = coin_valid ? '0 : pay_cnt_q + 1'b1;
                // Refund includes a coin arriving with cancel; cancel beats reaching total
                if (cancel) begin
                    change_d = paid_new;
                    state_d  = S_DONE;
                end else if (!coin_valid && pay_cnt_q == PAY_CNT_W'(PAY_TIMEOUT - 1)) begin
                    change_d = paid;
                    state_d  = S_DONE;
                end else if (paid_new >= total) begin
                    change_d = paid_new - total;
                    state_d  = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                ack_cnt_d = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (disp_ack) begin
                    dlv_d = dlv_q + 3'd1;
                    if (dlv_q + 3'd1 == qty_q) begin
                        ok_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DISPENSE;
                    end
                end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                    change_d = paid - sold_amt;
                    state_d  = S_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d           = (state_d != S_IDLE);
        disp_req_d       = (state_d == S_WAIT_ACK);
        disp_slot_d      = disp_req_d ? slot_d : 3'd0;
        finish_d         = (state_d == S_DONE);
        success_d        = finish_d & ok_d;
        out_d            = finish_d & soldout_d;
        sale_inc_valid_d = finish_d && (dlv_d != 3'd0);
        sale_inc_d       = sale_inc_valid_d ? MONEY_W'(price_d) * MONEY_W'(dlv_d) : '0;
    end

    // State and output registers; rst_n is an active-high synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_IDLE;
            slot_q         <= '0;
            qty_q          <= '0;
            price_q        <= '0;
            dlv_q          <= '0;
            pay_cnt_q      <= '0;
            ack_cnt_q      <= '0;
            ok_q           <= 1'b0;
            soldout_q      <= 1'b0;
            paid           <= '0;
            total          <= '0;
            change         <= '0;
            busy           <= 1'b0;
            disp_req       <= 1'b0;
            disp_slot      <= '0;
            finish         <= 1'b0;
            success        <= 1'b0;
            out            <= 1'b0;
            sale_inc_valid <= 1'b0;
            sale_inc       <= '0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            qty_q          <= qty_d;
            price_q        <= price_d;
            dlv_q          <= dlv_d;
            pay_cnt_q      <= pay_cnt_d;
            ack_cnt_q      <= ack_cnt_d;
            ok_q           <= ok_d;
            soldout_q      <= soldout_d;
            paid           <= paid_d;
            total          <= total_d;
            change         <= change_d;
            busy           <= busy_d;
            disp_req       <= disp_req_d;
            disp_slot      <= disp_slot_d;
            finish         <= finish_d;
            success        <= success_d;
            out            <= out_d;
            sale_inc_valid <= sale_inc_valid_d;
            sale_inc       <= sale_inc_d;
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with shortened payment and ack timeouts.
module tb_vend_txn_ctrl;

    localparam int unsigned MONEY_W = 11;
    localparam int unsigned PRICE_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [2:0]         slot = '0;
    logic [2:0]         qty = '0;
    logic [PRICE_W-1:0] price = '0;
    logic [3:0]         stock = '0;
    logic               coin_valid = 1'b0;
    logic [1:0]         coin_val = '0;
    logic               cancel = 1'b0;
    logic               disp_req;
    logic [2:0]         disp_slot;
    logic               disp_ack = 1'b0;
    logic [MONEY_W-1:0] paid, total, change, sale_inc;
    logic               busy, finish, success, out, sale_inc_valid;

    int checks = 0;
    int errors = 0;

    vend_txn_ctrl #(
        .QTY_MAX(4), .PRICE_W(PRICE_W), .MONEY_W(MONEY_W),
        .PAY_TIMEOUT(100), .ACK_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .slot(slot), .qty(qty),
        .price(price), .stock(stock), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .disp_req(disp_req), .disp_slot(disp_slot),
        .disp_ack(disp_ack), .paid(paid), .total(total), .change(change),
        .busy(busy), .finish(finish), .success(success), .out(out),
        .sale_inc_valid(sale_inc_valid), .sale_inc(sale_inc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic begin_txn(input logic [2:0] s, input logic [2:0] q,
                             input logic [7:0] p, input logic [3:0] st);
        slot = s; qty = q; price = p; stock = st; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!disp_req && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(disp_req), 32'd1);
    endtask

    task automatic ack();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_paid", 32'(paid), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_disp_req", 32'(disp_req), 0);
        rst_n = 1'b0;
        tick();

        // Normal two-item sale with change
        begin_txn(3'd3, 3'd2, 8'd12, 4'd5);
        chk("t1_total", 32'(total), 24);
        chk("t1_busy", 32'(busy), 1);
        coin(2'b10);
        coin(2'b10);
        chk("t1_paid20", 32'(paid), 20);
        coin(2'b01);
        chk("t1_paid25", 32'(paid), 25);
        chk("t1_change", 32'(change), 1);
        wait_req("t1_req1");
        chk("t1_slot", 32'(disp_slot), 3);
        ack();
        chk("t1_req_drop", 32'(disp_req), 0);
        wait_req("t1_req2");
        ack();
        chk("t1_finish", 32'(finish), 1);
        chk("t1_success", 32'(success), 1);
        chk("t1_sale_v", 32'(sale_inc_valid), 1);
        chk("t1_sale", 32'(sale_inc), 24);
        chk("t1_out", 32'(out), 0);
        tick();
        chk("t1_finish_pulse", 32'(finish), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_change_hold", 32'(change), 1);

        // Sold out in CHECK
        slot = 3'd1; qty = 3'd3; price = 8'd30; stock = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t2_finish", 32'(finish), 1);
        chk("t2_out", 32'(out), 1);
        chk("t2_success", 32'(success), 0);
        chk("t2_change", 32'(change), 0);
        chk("t2_total", 32'(total), 90);
        chk("t2_req", 32'(disp_req), 0);
        chk("t2_sale_v", 32'(sale_inc_valid), 0);
        tick();

        // Coin and cancel together: coin counted, cancel wins over total
        begin_txn(3'd2, 3'd1, 8'd15, 4'd5);
        coin(2'b01);
        repeat (9) tick();
        coin_valid = 1'b1; coin_val = 2'b10; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("t3_finish", 32'(finish), 1);
        chk("t3_success", 32'(success), 0);
        chk("t3_change", 32'(change), 15);
        chk("t3_req", 32'(disp_req), 0);
        tick();

        // Payment timeout after a single coin
        begin_txn(3'd4, 3'd1, 8'd50, 4'd5);
        coin(2'b01);
        n = 0;
        while (!finish && n < 200) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 100);
        chk("t4_change", 32'(change), 5);
        chk("t4_success", 32'(success), 0);
        tick();

        // Ack timeout on the second of three items
        begin_txn(3'd5, 3'd3, 8'd20, 4'd9);
        coin(2'b11);
        coin(2'b11);
        coin(2'b11);
        chk("t5_paid", 32'(paid), 60);
        wait_req("t5_req1");
        ack();
        wait_req("t5_req2");
        n = 0;
        while (!finish && n < 100) begin
            tick();
            n++;
        end
        chk("t5_ack_cycles", 32'(n), 20);
        chk("t5_success", 32'(success), 0);
        chk("t5_change", 32'(change), 40);
        chk("t5_sale_v", 32'(sale_inc_valid), 1);
        chk("t5_sale", 32'(sale_inc), 20);
        tick();

        // Reset while waiting for ack, then a fresh sale
        begin_txn(3'd6, 3'd1, 8'd7, 4'd1);
        coin(2'b10);
        wait_req("t6_req");
        rst_n = 1'b1;
        tick();
        chk("t6_req", 32'(disp_req), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_paid", 32'(paid), 0);
        chk("t6_change", 32'(change), 0);
        chk("t6_total", 32'(total), 0);
        chk("t6_finish", 32'(finish), 0);
        rst_n = 1'b0;
        tick();
        begin_txn(3'd7, 3'd1, 8'd5, 4'd3);
        coin(2'b01);
        wait_req("t6b_req");
        chk("t6b_slot", 32'(disp_slot), 7);
        ack();
        chk("t6b_finish", 32'(finish), 1);
        chk("t6b_success", 32'(success), 1);
        chk("t6b_sale", 32'(sale_inc), 5);
        chk("t6b_change", 32'(change), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
